// File: rtl/arm_fetch_unit_if.sv
// Instruction memory fetch bus between the fetch unit (master) and instruction memory (slave).
interface arm_fetch_unit_if #(
   parameter int unsigned ADDR_W = 6
) ();
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/arm_fetch_unit.sv
// ARM instruction fetch stage: prefetch queue over a variable-latency memory,
// IR load on Write_IR, condition-field evaluation against NZCV, and fetch redirect.
module arm_fetch_unit #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned QDEPTH = 2
) (
   input  logic                 clk,
   input  logic                 Rst,
   arm_fetch_unit_if.master     mem,
   input  logic                 Write_IR,
   input  logic [3:0]           NZCV,
   input  logic                 flush,
   input  logic [ADDR_W-1:0]    flush_addr,
   output logic [31:0]          IR,
   output logic [ADDR_W-1:0]    Inst_addr,
   output logic                 IR_valid,
   output logic                 flag,
   output logic                 stall
);
   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } entry_t;

   typedef enum logic [1:0] {F_IDLE, F_REQ, F_FULL} state_t;

   state_t            state, state_next;
   entry_t            queue [QDEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count, count_next;
   logic [ADDR_W-1:0] pc, redirect;
   logic              discard;
   logic              ack_now, pop, push;

   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'b0000: cond_pass = z;
         4'b0001: cond_pass = !z;
         4'b0010: cond_pass = cf;
         4'b0011: cond_pass = !cf;
         4'b0100: cond_pass = n;
         4'b0101: cond_pass = !n;
         4'b0110: cond_pass = v;
         4'b0111: cond_pass = !v;
         4'b1000: cond_pass = cf & !z;
         4'b1001: cond_pass = !cf | z;
         4'b1010: cond_pass = (n == v);
         4'b1011: cond_pass = (n != v);
         4'b1100: cond_pass = !z & (n == v);
         4'b1101: cond_pass = z | (n != v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   // Queue handshake; a same-cycle ack never bypasses into IR
   always_comb begin
      ack_now    = (state == F_REQ) && mem.mem_ack;
      pop        = Write_IR && (count != '0) && !flush;
      push       = ack_now && !discard && !flush && ((count < FULL_CNT) || pop);
      count_next = flush ? '0 : CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) state <= F_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         F_IDLE: state_next = F_REQ;
         F_REQ:  if (ack_now && (count_next == FULL_CNT)) state_next = F_FULL;
         F_FULL: if (count_next != FULL_CNT) state_next = F_REQ;
         default: state_next = F_IDLE;
      endcase
   end

   always_comb begin
      mem.mem_req = 1'b0;
      if (state == F_REQ) mem.mem_req = 1'b1;
   end

   assign mem.mem_addr = pc;
   assign flag         = IR_valid & cond_pass(IR[31:28], NZCV);
   assign stall        = Write_IR & (count == '0);

   always_ff @(posedge clk) begin
      if (push) queue[wr_ptr] <= '{addr: pc, data: mem.mem_rdata};
   end

   // A flush during an unacknowledged request keeps mem_addr stable and parks the target
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         pc        <= '0;
         redirect  <= '0;
         discard   <= 1'b0;
         IR        <= '0;
         Inst_addr <= '0;
         IR_valid  <= 1'b0;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         IR_valid <= 1'b0;
         if ((state == F_REQ) && !mem.mem_ack) begin
            discard  <= 1'b1;
            redirect <= flush_addr;
         end else begin
            discard <= 1'b0;
            pc      <= flush_addr;
         end
      end else begin
         count <= count_next;
         if (pop) begin
            IR        <= queue[rd_ptr].data;
            Inst_addr <= queue[rd_ptr].addr;
            IR_valid  <= 1'b1;
            rd_ptr    <= PTR_W'(rd_ptr + 1'b1);
         end
         if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
         if (ack_now) begin
            if (discard) begin
               pc      <= redirect;
               discard <= 1'b0;
            end else begin
               pc <= ADDR_W'(pc + 1'b1);
            end
         end
      end
   end
endmodule

// File: tb/tb_arm_fetch_unit.sv
// Self-checking bench for arm_fetch_unit: directed scenarios plus random traffic
// checked against a queue-level reference model.
module tb_arm_fetch_unit;
   localparam int unsigned ADDR_W = 6;
   localparam int unsigned QDEPTH = 2;

   typedef struct packed {
      logic [5:0]  addr;
      logic [31:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        Rst;
   logic        Write_IR, flush;
   logic [3:0]  NZCV;
   logic [5:0]  flush_addr;
   logic [31:0] IR;
   logic [5:0]  Inst_addr;
   logic        IR_valid, flag, stall;

   arm_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

   arm_fetch_unit #(.ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
      .clk(clk), .Rst(Rst), .mem(bus), .Write_IR(Write_IR), .NZCV(NZCV),
      .flush(flush), .flush_addr(flush_addr), .IR(IR), .Inst_addr(Inst_addr),
      .IR_valid(IR_valid), .flag(flag), .stall(stall)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mem [64];
   ent_t        mq [$];
   logic [31:0] m_ir;
   logic [5:0]  m_ia, exp_pc, pend_addr;
   logic        m_valid;
   bit          pending, pend_drop, idle;
   int          waited, lat;
   logic [3:0]  nzcv;

   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cf, v;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c)
         0: return z;          1: return !z;
         2: return cf;         3: return !cf;
         4: return n;          5: return !n;
         6: return v;          7: return !v;
         8: return cf && !z;   9: return !cf || z;
         10: return n == v;    11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s observed=timeout expected=event", tag);
   endtask

   task automatic model_reset();
      mq.delete();
      m_ir = '0; m_ia = '0; m_valid = 1'b0; exp_pc = '0;
      pending = 0; pend_drop = 0; waited = 0; idle = 1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_IR"}, IR, 32'h0);
      chk({tag, "_Inst_addr"}, 32'(Inst_addr), 32'h0);
      chk({tag, "_IR_valid"}, 32'(IR_valid), 32'h0);
      chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'h0);
      chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'h0);
      chk({tag, "_flag"}, 32'(flag), 32'h0);
      chk({tag, "_stall"}, 32'(stall), 32'h0);
   endtask

   // Synchronous-style reset, released at a falling edge
   task automatic do_reset();
      Rst = 1'b1; Write_IR = 1'b0; flush = 1'b0; bus.mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      Rst = 1'b0;
      model_reset();
   endtask

   // Reset asserted asynchronously between clock edges
   task automatic async_reset(input string tag);
      #2;
      Rst = 1'b1; Write_IR = 1'b0; flush = 1'b0; bus.mem_ack = 1'b0;
      #1;
      check_reset_outputs(tag);
      @(posedge clk);
      @(negedge clk);
      Rst = 1'b0;
      model_reset();
   endtask

   // One clock: drive at negedge, compare against the model, then advance the model
   task automatic cycle(input bit wr, input bit fl, input logic [5:0] fa);
      logic       rq;
      logic [5:0] ad;
      bit         ack;
      ent_t       e;
      Write_IR = wr; flush = fl; flush_addr = fa; NZCV = nzcv;
      rq  = bus.mem_req;
      ad  = bus.mem_addr;
      ack = rq && (waited >= lat);
      bus.mem_ack   = ack;
      bus.mem_rdata = ack ? mem[ad] : $urandom();
      #1;
      chk("IR", IR, m_ir);
      chk("Inst_addr", 32'(Inst_addr), 32'(m_ia));
      chk("IR_valid", 32'(IR_valid), 32'(m_valid));
      chk("flag", 32'(flag), 32'(m_valid && cond_ok(m_ir[31:28], nzcv)));
      chk("stall", 32'(stall), 32'(wr && (mq.size() == 0)));
      if (idle) chk("mem_req_idle", 32'(rq), 32'h0);
      else      chk("mem_req", 32'(rq), 32'(mq.size() < QDEPTH));
      if (rq) chk("mem_addr", 32'(ad), 32'(pending ? pend_addr : exp_pc));
      idle = 0;
      @(posedge clk);
      if (fl) begin
         mq.delete();
         m_valid = 1'b0;
         exp_pc  = fa;
      end else begin
         if (wr && (mq.size() > 0)) begin
            e = mq.pop_front();
            m_ir = e.data; m_ia = e.addr; m_valid = 1'b1;
         end
         if (ack && !pend_drop) begin
            e.addr = ad; e.data = mem[ad];
            mq.push_back(e);
            exp_pc = 6'(ad + 6'd1);
         end
      end
      if (rq && !ack) begin
         if (!pending) pend_addr = ad;
         pending = 1;
         if (fl) pend_drop = 1;
         waited++;
      end else begin
         pending = 0; pend_drop = 0; waited = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      bit done;
      Rst = 1'b1; Write_IR = 1'b0; flush = 1'b0; flush_addr = '0; NZCV = '0;
      bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      nzcv = 4'b0000; lat = 0;
      for (int i = 0; i < 64; i++) mem[i] = $urandom();
      mem[0] = 32'hE0810002; mem[1] = 32'hE2422001;
      mem[2] = 32'h10433004; mem[3] = 32'hF0000000;

      // Zero-wait memory, Write_IR every fourth cycle
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         cycle((i % 4) == 3, 1'b0, '0);
         if (i == 3) chk("first_ir", IR, 32'hE0810002);
      end
      chk("seq_last_addr", 32'(Inst_addr), 32'd3);

      // Three-cycle memory latency with Write_IR held high
      do_reset();
      lat = 3;
      for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, '0);

      // Queue fills with no consumer, then one pop re-opens fetch at QDEPTH
      do_reset();
      lat = 0;
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, '0);
      chk("refill_req", 32'(bus.mem_req), 32'h1);
      chk("refill_addr", 32'(bus.mem_addr), 32'(QDEPTH));
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);

      // Redirect to 20 while the request for address 5 is still waiting
      do_reset();
      lat = 3;
      done = 0;
      for (int i = 0; i < 200 && !done; i++)
         if (bus.mem_req && bus.mem_addr == 6'd5 && waited == 1) begin
            cycle(1'b1, 1'b1, 6'd20);
            done = 1;
         end else cycle(1'b1, 1'b0, '0);
      if (!done) timeout("flush_trigger");
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         cycle(1'b1, 1'b0, '0);
         if (IR_valid) done = 1;
      end
      if (done) begin
         chk("flush_first_addr", 32'(Inst_addr), 32'd20);
         chk("flush_first_ir", IR, mem[20]);
      end else timeout("flush_first_ir");

      // Fetch PC wraps from 63 to 0
      lat = 0;
      cycle(1'b0, 1'b1, 6'd62);
      for (int i = 0; i < 14; i++) cycle(i[0], 1'b0, '0);

      // Condition field sweep over every NZCV value
      for (int c = 0; c < 16; c++) begin
         mem[40] = {4'(c), 28'($urandom())};
         cycle(1'b0, 1'b1, 6'd40);
         done = 0;
         for (int i = 0; i < 10 && !done; i++) begin
            cycle(mq.size() > 0, 1'b0, '0);
            if (m_valid) done = 1;
         end
         if (!done) timeout("cond_load");
         for (int f = 0; f < 16; f++) begin
            nzcv = 4'(f);
            cycle(1'b0, 1'b0, '0);
         end
      end

      // Random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         lat  = $urandom_range(0, 3);
         nzcv = 4'($urandom());
         cycle(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, 6'($urandom()));
      end

      // Asynchronous reset mid-request, then with a full queue
      lat = 3;
      cycle(1'b0, 1'b1, 6'd9);
      cycle(1'b0, 1'b0, '0);
      async_reset("areset_req");
      lat = 0;
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
      chk("full_before_reset", 32'(mq.size()), 32'(QDEPTH));
      async_reset("areset_full");
      for (int i = 0; i < 8; i++) cycle(i[0], 1'b0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
